// File: rtl/inst_fetch_if.sv
// Fetch-side bus bundle: instruction memory port, execute redirect, and decode handshake.
interface inst_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr,
        input  imem_dout,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_dout,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        input  fetch_count
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC register, zero-latency imem read, small fetch queue
// toward decode, and redirect-driven flush.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fcount_q, fcount_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_inst_q, out_inst_d;
    logic [31:0]      out_pc_q, out_pc_d;

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];

    logic             pop;
    logic             can_push;
    logic             push;

    assign bus.imem_addr   = pc_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_inst    = out_inst_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.fetch_count = fcount_q;

    // Next-state: redirect flushes and retargets, otherwise fetch and drain in parallel.
    always_comb begin
        pc_d        = pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        fcount_d    = fcount_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        push        = 1'b0;
        pop         = out_valid_q & bus.out_ready;
        can_push    = (count_q < DEPTH_C) | pop;

        if (bus.redirect_valid) begin
            pc_d        = {bus.redirect_pc[31:2], 2'b00};
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            push = can_push;
            if (push) begin
                pc_d     = pc_q + 32'd4;
                tail_d   = tail_q + PTR_W'(1);
                fcount_d = fcount_q + 32'd1;
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
            out_valid_d = (count_d != '0);
            // Head is either the entry being written this edge (queue drained) or stored.
            if (count_d != '0) begin
                if (count_q == CNT_W'(pop)) begin
                    out_inst_d = bus.imem_dout;
                    out_pc_d   = pc_q;
                end else begin
                    out_inst_d = inst_mem[head_d];
                    out_pc_d   = pc_mem[head_d];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= PC_INIT;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            fcount_q    <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            fcount_q    <= fcount_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
        end
    end

    // Queue storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail_q] <= bus.imem_dout;
            pc_mem[tail_q]   <= pc_q;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Randomized and directed bench for inst_fetch against a queue-based reference model.
module tb_inst_fetch;
    localparam int unsigned DEPTH = 2;

    logic clk;
    logic rst;
    inst_fetch_if bus ();

    int n_tests;
    int n_fail;

    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_fc;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_inst;
    logic [31:0] saved_fc;

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'hA000_0000 + 32'(addr[4:2]);
    endfunction

    assign bus.imem_dout = mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc        = 32'h0;
        m_fc        = 32'h0;
        m_last_pc   = 32'h0;
        m_last_inst = 32'h0;
    endtask

    task automatic check_all();
        logic [63:0] h;
        check("valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        check("imem_addr", bus.imem_addr, m_pc);
        check("fetch_count", bus.fetch_count, m_fc);
        if (mq.size() != 0) begin
            h = mq[0];
            check("out_pc", bus.out_pc, h[63:32]);
            check("out_inst", bus.out_inst, h[31:0]);
        end else begin
            check("hold_pc", bus.out_pc, m_last_pc);
            check("hold_inst", bus.out_inst, m_last_inst);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check on the falling edge.
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic pop;
        logic can;
        logic [63:0] h;
        bus.out_ready      = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        @(posedge clk);
        pop = (mq.size() != 0) && rdy;
        can = (mq.size() < DEPTH) || pop;
        if (redir) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (can) begin
                mq.push_back({m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
                m_fc = m_fc + 32'd1;
            end
        end
        if (mq.size() != 0) begin
            h           = mq[0];
            m_last_pc   = h[63:32];
            m_last_inst = h[31:0];
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        rst = 1'b1;
        @(negedge clk);

        // Streaming from reset with decode always ready, including address aliasing.
        do_reset();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b0, 32'h0);
            check("t1_pc", bus.out_pc, 32'(k * 4));
            check("t1_inst", bus.out_inst, 32'hA000_0000 + 32'(k % 8));
        end

        // Decode stalled: queue fills, PC holds, then drains in order.
        do_reset();
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 32'h0);
        check("t2_addr", bus.imem_addr, 32'h8);
        check("t2_fc", bus.fetch_count, 32'd2);
        for (int k = 0; k < 3; k++) begin
            check("t2_drain", bus.out_pc, 32'(k * 4));
            cycle(1'b1, 1'b0, 32'h0);
        end

        // Redirect to a misaligned target while full and stalled.
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h16);
        check("t3_flush", 32'(bus.out_valid), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        check("t3_pc", bus.out_pc, 32'h14);
        check("t3_inst", bus.out_inst, 32'hA000_0005);
        cycle(1'b1, 1'b0, 32'h0);
        check("t3_next", bus.out_pc, 32'h18);

        // Redirect and pop together at full occupancy.
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        saved_fc = m_fc;
        cycle(1'b1, 1'b1, 32'h40);
        check("t4_fc", bus.fetch_count, saved_fc);
        check("t4_flush", 32'(bus.out_valid), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        check("t4_pc", bus.out_pc, 32'h40);

        // PC wraparound.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0);
        check("t5_pc0", bus.out_pc, 32'hFFFF_FFFC);
        check("t5_inst0", bus.out_inst, 32'hA000_0007);
        cycle(1'b1, 1'b0, 32'h0);
        check("t5_pc1", bus.out_pc, 32'h0000_0000);
        check("t5_inst1", bus.out_inst, 32'hA000_0000);

        // Asynchronous reset between edges.
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 32'h0);
        #1 rst = 1'b1;
        #1;
        check("t6_valid", 32'(bus.out_valid), 32'd0);
        check("t6_fc", bus.fetch_count, 32'd0);
        check("t6_addr", bus.imem_addr, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
        cycle(1'b1, 1'b0, 32'h0);
        check("t6_restart", bus.out_pc, 32'h0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0),
                  $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
